// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for common-anode 7-segment
// digits sharing one segment bus. Each digit is lit for CLK_DIV cycles, then
// all digits are dark for BLANK_CYC cycles (anti-ghosting gap). New frames
// arrive through a load/ack handshake and are applied only at frame
// boundaries (wrap to digit 0, or the IDLE->SHOW start of scanning), so a
// partially updated frame is never displayed.
//
// Optional feature macro: SEG_LZB_EN (leading-zero blanking).
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         scan enable, low = display dark
//   data_in    frame of hex nibbles, digit i = data_in[4i+3:4i]
//   dp_in      decimal-point request per digit, 1 = on
//   load       1-cycle request to capture data_in/dp_in
//   ack        1-cycle pulse: captured frame is now being displayed
//   seg        active-low segments {g,f,e,d,c,b,a}
//   dp_n       active-low decimal point
//   dig_n      active-low digit select, at most one bit low
//   frame_done 1-cycle pulse marking the cycle of the frame boundary
module seg_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [4*DIGITS-1:0] data_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                load,
    output logic                ack,
    output logic [6:0]          seg,
    output logic                dp_n,
    output logic [DIGITS-1:0]   dig_n,
    output logic                frame_done
);

    localparam int DW   = 4 * DIGITS;
    localparam int IW   = $clog2(DIGITS);
    localparam int MAXC = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h18;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h27;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     disp_q, disp_d, pend_q, pend_d;
    logic [DIGITS-1:0] disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic              pend_vld_q, pend_vld_d;
    logic              ack_dly_q, ack_dly_d;
    logic              ack_q, ack_d;
    logic              fd_q, fd_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_n_q, dp_n_d;
    logic [DIGITS-1:0] dig_n_q, dig_n_d;
    logic              boundary;
    logic [3:0]        nib_cur;
    logic [6:0]        seg_show;

    // Scan sequencing; boundary marks the cycles where a new frame may be applied.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;
        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = SHOW;
                    idx_d    = '0;
                    cnt_d    = '0;
                    boundary = 1'b1;
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // frame_done is high during the last BLANK cycle of the last digit, i.e.
    // the cycle whose closing edge is the frame boundary, so a load issued
    // while frame_done is high lands exactly on the boundary.
    assign fd_d = (state_d == BLANK) && (idx_d == IDX_LAST) && (cnt_d == BLANK_LAST);

    // Frame handshake. A load coinciding with a boundary bypasses the pending
    // register; its ack comes one cycle later through ack_dly_q.
    always_comb begin
        disp_d     = disp_q;
        disp_dp_d  = disp_dp_q;
        pend_d     = pend_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        ack_dly_d  = 1'b0;
        ack_d      = ack_dly_q;
        if (boundary && load) begin
            disp_d     = data_in;
            disp_dp_d  = dp_in;
            pend_vld_d = 1'b0;
            ack_dly_d  = 1'b1;
        end else if (boundary && pend_vld_q) begin
            disp_d     = pend_q;
            disp_dp_d  = pend_dp_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
        end else if (load) begin
            pend_d     = data_in;
            pend_dp_d  = dp_in;
            pend_vld_d = 1'b1;
        end
    end

    assign nib_cur = disp_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_LZB_EN
    // A digit is blanked when it and every more-significant nibble are zero,
    // unless it is digit 0 or carries a decimal point.
    logic [DIGITS-1:0] lzb;
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lzb        = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (disp_q[4*i +: 4] == 4'h0);
            lzb[i]     = zero_above & ~disp_dp_q[i] & (i != 0);
        end
    end
    assign seg_show = lzb[idx_q] ? 7'h7F : seg_decode(nib_cur);
`else
    assign seg_show = seg_decode(nib_cur);
`endif

    // Gating with en darkens the pins in the very cycle after en falls.
    always_comb begin
        seg_d   = 7'h7F;
        dp_n_d  = 1'b1;
        dig_n_d = '1;
        if (en && (state_q == SHOW)) begin
            seg_d   = seg_show;
            dp_n_d  = ~disp_dp_q[idx_q];
            dig_n_d = ~(DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            disp_q     <= '0;
            disp_dp_q  <= '0;
            pend_q     <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            ack_dly_q  <= 1'b0;
            ack_q      <= 1'b0;
            fd_q       <= 1'b0;
            seg_q      <= 7'h7F;
            dp_n_q     <= 1'b1;
            dig_n_q    <= '1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            disp_dp_q  <= disp_dp_d;
            pend_q     <= pend_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            ack_dly_q  <= ack_dly_d;
            ack_q      <= ack_d;
            fd_q       <= fd_d;
            seg_q      <= seg_d;
            dp_n_q     <= dp_n_d;
            dig_n_q    <= dig_n_d;
        end
    end

    assign ack        = ack_q;
    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign dig_n      = dig_n_q;
    assign frame_done = fd_q;

endmodule
